// File: rtl/stoch_max_pkg.sv
// stoch_max_pkg: scan state encoding and the signed per-cycle difference term
// shared by the stochastic argmax scheduler and its accumulator.
package stoch_max_pkg;

    typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_DECIDE, S_HOLD} state_t;

    typedef logic signed [2:0] dterm_t;

    // (a_p - a_m) - (b_p - b_m): champion minus candidate, always within -2..+2
    function automatic dterm_t diff_term(input logic a_p, input logic a_m,
                                         input logic b_p, input logic b_m);
        return $signed({2'b00, a_p}) - $signed({2'b00, a_m})
             - $signed({2'b00, b_p}) + $signed({2'b00, b_m});
    endfunction

endpackage

// File: rtl/stoch_signed_diff_counter.sv
// stoch_signed_diff_counter: signed up/down accumulator stepped by a small d term,
// clamping at the two's-complement limits instead of wrapping.
module stoch_signed_diff_counter
    import stoch_max_pkg::*;
#(
    parameter int COUNTER_SIZE = 8
) (
    input  logic                           CLK,
    input  logic                           nRST,
    input  logic                           clear,
    input  logic                           en,
    input  dterm_t                         d,
    output logic signed [COUNTER_SIZE-1:0] acc
);

    localparam logic signed [COUNTER_SIZE:0] MAX = {2'b00, {(COUNTER_SIZE-1){1'b1}}};
    localparam logic signed [COUNTER_SIZE:0] MIN = {2'b11, {(COUNTER_SIZE-1){1'b0}}};

    logic signed [COUNTER_SIZE:0] w_sum;

    // one guard bit is enough since |d| <= 2
    assign w_sum = {acc[COUNTER_SIZE-1], acc} + {{(COUNTER_SIZE-2){d[2]}}, d};

    always_ff @(posedge CLK) begin
        if (!nRST || clear)
            acc <= '0;
        else if (en)
            acc <= (w_sum > MAX) ? MAX[COUNTER_SIZE-1:0] :
                   (w_sum < MIN) ? MIN[COUNTER_SIZE-1:0] : w_sum[COUNTER_SIZE-1:0];
    end

endmodule

// File: rtl/stoch_max_scheduler.sv
// stoch_max_scheduler: sequential knockout argmax over signed stochastic streams;
// each champion/candidate match integrates their bit difference for WINDOW cycles.
module stoch_max_scheduler
    import stoch_max_pkg::*;
#(
    parameter int N_INPUTS     = 4,
    parameter int COUNTER_SIZE = 8,
    parameter int WINDOW       = 64,
    localparam int IDX_W       = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                start,
    input  logic [N_INPUTS-1:0] x_p,
    input  logic [N_INPUTS-1:0] x_m,
    output logic                busy,
    output logic                done,
    output logic [IDX_W-1:0]    idx,
    output logic                y_p,
    output logic                y_m
);

    localparam int WCNT_W = $clog2(WINDOW + 1);
    localparam int XW     = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_INPUTS - 1);

    state_t                          r_state, w_state;
    logic [IDX_W-1:0]                r_champ, r_cand, r_idx, w_champ, w_cand, w_idx;
    logic [WCNT_W-1:0]               r_wcnt, w_wcnt;
    logic                            r_done, r_y_p, r_y_m, w_enter, w_clear, w_en;
    logic [XW-1:0]                   w_xp, w_xm;
    logic signed [COUNTER_SIZE-1:0]  w_acc;
    dterm_t                          w_d;

    // padding to a power of two keeps every champ/cand/idx select in range
    assign w_xp = XW'(x_p);
    assign w_xm = XW'(x_m);
    assign w_d  = diff_term(w_xp[r_champ], w_xm[r_champ], w_xp[r_cand], w_xm[r_cand]);

    stoch_signed_diff_counter #(.COUNTER_SIZE(COUNTER_SIZE)) u_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .clear (w_clear),
        .en    (w_en),
        .d     (w_d),
        .acc   (w_acc)
    );

    always_comb begin
        w_state = r_state;
        w_champ = r_champ;
        w_cand  = r_cand;
        w_wcnt  = r_wcnt;
        w_idx   = r_idx;
        w_enter = 1'b0;
        w_clear = 1'b0;
        w_en    = 1'b0;
        case (r_state)
            S_IDLE, S_HOLD: if (start) begin
                w_state = (N_INPUTS == 1) ? S_HOLD : S_COMPARE;
                w_champ = '0;
                w_cand  = IDX_W'(1);
                w_wcnt  = '0;
                w_clear = 1'b1;
                w_enter = (N_INPUTS == 1);
                if (N_INPUTS == 1) w_idx = '0;
            end
            S_COMPARE: begin
                w_en   = 1'b1;
                w_wcnt = r_wcnt + 1'b1;
                if (r_wcnt == WCNT_W'(WINDOW - 1)) w_state = S_DECIDE;
            end
            S_DECIDE: begin
                w_champ = (w_acc < 0) ? r_cand : r_champ;
                w_clear = 1'b1;
                w_wcnt  = '0;
                if (r_cand == LAST) begin
                    w_state = S_HOLD;
                    w_idx   = w_champ;
                    w_enter = 1'b1;
                end else begin
                    w_state = S_COMPARE;
                    w_cand  = r_cand + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= S_IDLE;
            r_champ <= '0;
            r_cand  <= '0;
            r_wcnt  <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_y_p   <= 1'b0;
            r_y_m   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_champ <= w_champ;
            r_cand  <= w_cand;
            r_wcnt  <= w_wcnt;
            r_idx   <= w_idx;
            r_done  <= w_enter;
            r_y_p   <= (w_state == S_HOLD) && w_xp[w_idx];
            r_y_m   <= (w_state == S_HOLD) && w_xm[w_idx];
        end
    end

    assign busy = (r_state == S_COMPARE) || (r_state == S_DECIDE);
    assign done = r_done;
    assign idx  = r_idx;
    assign y_p  = r_y_p;
    assign y_m  = r_y_m;

endmodule

// File: tb/tb_stoch_max_scheduler.sv
// tb_stoch_max_scheduler: fixed-level vector table, random Bernoulli scans checked against
// a knockout-tournament model, plus reset, saturation and single-input sequences.
`timescale 1ns/1ps
module tb_stoch_max_scheduler;

    localparam int N = 4;
    localparam int W = 64;
    localparam int C = 8;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    logic         start = 1'b0;
    logic [N-1:0] x_p = '0, x_m = '0;
    logic         busy, done, y_p, y_m;
    logic [1:0]   idx;

    logic         s_start = 1'b0;
    logic [1:0]   s_xp = '0, s_xm = '0;
    logic         s_busy, s_done, s_yp, s_ym, s_idx;

    logic         o_start = 1'b0, o_xp = 1'b0, o_xm = 1'b0;
    logic         o_busy, o_done, o_yp, o_ym, o_idx;

    stoch_max_scheduler #(.N_INPUTS(N), .COUNTER_SIZE(C), .WINDOW(W)) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .x_p(x_p), .x_m(x_m),
        .busy(busy), .done(done), .idx(idx), .y_p(y_p), .y_m(y_m));

    stoch_max_scheduler #(.N_INPUTS(2), .COUNTER_SIZE(4), .WINDOW(16)) dut_s (
        .CLK(CLK), .nRST(nRST), .start(s_start), .x_p(s_xp), .x_m(s_xm),
        .busy(s_busy), .done(s_done), .idx(s_idx), .y_p(s_yp), .y_m(s_ym));

    stoch_max_scheduler #(.N_INPUTS(1), .COUNTER_SIZE(C), .WINDOW(W)) dut_1 (
        .CLK(CLK), .nRST(nRST), .start(o_start), .x_p(o_xp), .x_m(o_xm),
        .busy(o_busy), .done(o_done), .idx(o_idx), .y_p(o_yp), .y_m(o_ym));

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int v, input int bits);
        int hi, lo;
        hi = (1 << (bits - 1)) - 1;
        lo = -(1 << (bits - 1));
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

    function automatic int val(input logic [N-1:0] p, input logic [N-1:0] m, input int i);
        return int'(p[i]) - int'(m[i]);
    endfunction

    // 0: fixed levels, 1: independent Bernoulli per requester, 2: one shared +0.5 stream
    int           mode = 0;
    logic [N-1:0] fix_p = '0, fix_m = '0;
    real          prob [N];

    task automatic gen_bits();
        int r;
        bit b;
        if (mode == 0) begin
            x_p = fix_p;
            x_m = fix_m;
        end else if (mode == 2) begin
            b = ($urandom_range(0, 999) < 500);
            x_p = {N{b}};
            x_m = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                r = int'($urandom_range(0, 999));
                x_p[i] = (prob[i] > 0.0) && (r < int'(prob[i] * 1000.0));
                x_m[i] = (prob[i] < 0.0) && (r < int'(-prob[i] * 1000.0));
            end
        end
    endtask

    // One full scan: champion 0 meets candidates 1..N-1 in turn, each match summing
    // W differences of the bits actually driven; a negative total crowns the candidate.
    task automatic run_scan(input bit extra, output int m_idx);
        int champ, acc;
        logic [N-1:0] hp, hm;
        champ = 0;
        hp = '0;
        hm = '0;
        start = 1'b1;
        gen_bits();
        @(posedge CLK); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_after_start", done, 0);
        for (int k = 1; k < N; k++) begin
            acc = 0;
            for (int w = 0; w < W; w++) begin
                start = extra && (k == 1) && (w == 10 || w == 50);
                gen_bits();
                @(posedge CLK); #1;
                acc = clamp(acc + val(x_p, x_m, champ) - val(x_p, x_m, k), C);
                chk("scan_busy", busy, 1);
                chk("scan_done", done, 0);
                chk("scan_y_zero", {y_p, y_m}, 0);
            end
            start = 1'b0;
            gen_bits();
            hp = x_p;
            hm = x_m;
            @(posedge CLK); #1;
            if (acc < 0) champ = k;
            chk("decide_busy", busy, int'(k < N - 1));
            chk("decide_done", done, int'(k == N - 1));
        end
        chk("scan_idx", idx, champ);
        chk("first_hold_y", {y_p, y_m}, {hp[champ], hm[champ]});
        m_idx = champ;
    endtask

    task automatic hold_run(input int n, input int ex, output int ysum);
        logic [N-1:0] hp, hm;
        ysum = 0;
        for (int c = 0; c < n; c++) begin
            gen_bits();
            hp = x_p;
            hm = x_m;
            @(posedge CLK); #1;
            chk("hold_y", {y_p, y_m}, {hp[ex], hm[ex]});
            chk("hold_busy_done", {busy, done}, 0);
            chk("hold_idx", idx, ex);
            ysum += int'(y_p) - int'(y_m);
        end
    endtask

    // Two-input saturation match: constant d over 16 cycles clamps in a 4-bit accumulator
    task automatic sat_run(input logic [1:0] p, input logic [1:0] m);
        int d, exp_acc;
        d = (int'(p[0]) - int'(m[0])) - (int'(p[1]) - int'(m[1]));
        exp_acc = clamp(16 * d, 4);
        s_xp = p;
        s_xm = m;
        s_start = 1'b1;
        @(posedge CLK); #1;
        s_start = 1'b0;
        chk("sat_busy", s_busy, 1);
        for (int w = 1; w <= 16; w++) begin
            @(posedge CLK); #1;
            chk("sat_done_low", s_done, 0);
            chk("sat_acc_bound", int'(dut_s.u_cnt.acc), clamp(w * d, 4));
        end
        chk("sat_acc_final", int'(dut_s.u_cnt.acc), exp_acc);
        @(posedge CLK); #1;
        chk("sat_done", s_done, 1);
        chk("sat_idx", s_idx, int'(exp_acc < 0));
    endtask

    typedef struct {
        logic [N-1:0] xp;
        logic [N-1:0] xm;
        int           exp_idx;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int m, ysum;
        real mean;
        tbl[0] = '{4'b0000, 4'b0000, 0};
        tbl[1] = '{4'b0100, 4'b0000, 2};
        tbl[2] = '{4'b1111, 4'b0000, 0};
        tbl[3] = '{4'b1000, 4'b0111, 3};
        tbl[4] = '{4'b0010, 4'b0001, 1};
        tbl[5] = '{4'b0000, 4'b1110, 0};
        tbl[6] = '{4'b1010, 4'b0101, 1};
        tbl[7] = '{4'b0000, 4'b0001, 1};

        start = 1'b1;
        s_start = 1'b1;
        o_start = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", idx, 0);
        chk("rst_y", {y_p, y_m}, 0);
        chk("rst_s_busy", s_busy, 0);
        chk("rst_1_done", o_done, 0);
        start = 1'b0;
        s_start = 1'b0;
        o_start = 1'b0;
        nRST = 1'b1;
        @(posedge CLK); #1;
        chk("idle_busy", busy, 0);

        mode = 0;
        for (int i = 0; i < 8; i++) begin
            fix_p = tbl[i].xp;
            fix_m = tbl[i].xm;
            run_scan(1'b0, m);
            chk("tbl_idx", idx, tbl[i].exp_idx);
            hold_run(5, tbl[i].exp_idx, ysum);
        end

        mode = 1;
        prob = '{0.25, -0.5, 0.75, 0.5};
        run_scan(1'b1, m);
        hold_run(1000, m, ysum);
        mean = real'(ysum) / 1000.0;
        chk("y_mean_within_0p1", int'(mean - prob[m] <= 0.1 && prob[m] - mean <= 0.1), 1);

        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < N; i++) prob[i] = real'(int'($urandom_range(0, 200)) - 100) / 100.0;
            run_scan(1'b0, m);
            hold_run(20, m, ysum);
        end

        mode = 2;
        run_scan(1'b0, m);
        chk("identical_idx", idx, 0);
        hold_run(10, 0, ysum);

        mode = 0;
        fix_p = tbl[3].xp;
        fix_m = tbl[3].xm;
        run_scan(1'b0, m);
        mode = 1;
        start = 1'b1;
        gen_bits();
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (99) begin
            gen_bits();
            @(posedge CLK); #1;
        end
        chk("pre_reset_busy", busy, 1);
        nRST = 1'b0;
        start = 1'b1;
        @(posedge CLK); #1;
        nRST = 1'b1;
        start = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_idx", idx, 0);
        chk("midrst_done", done, 0);
        for (int c = 0; c < 200; c++) begin
            gen_bits();
            @(posedge CLK); #1;
            chk("post_rst_quiet", {busy, done, y_p, y_m}, 0);
        end

        sat_run(2'b01, 2'b10);
        sat_run(2'b10, 2'b01);

        o_xp = 1'b1;
        o_start = 1'b1;
        @(posedge CLK); #1;
        o_start = 1'b0;
        chk("n1_done", o_done, 1);
        chk("n1_busy", o_busy, 0);
        chk("n1_idx", o_idx, 0);
        chk("n1_y", o_yp, 1);
        for (int c = 0; c < 6; c++) begin
            o_xp = c[0];
            o_xm = ~c[0];
            @(posedge CLK); #1;
            chk("n1_hold_done", o_done, 0);
            chk("n1_hold_busy", o_busy, 0);
            chk("n1_hold_y", {o_yp, o_ym}, {c[0], ~c[0]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
